game_judge: RTL

Game-state and collision judge sitting directly downstream of the object controller. Each game tick it checks the dino position against every active obstacle position. It runs the IDLE/RUN/OVER game state machine and keeps the current and high scores. It emits a one-cycle restart pulse that re-initialises the object controller, plus a run enable that gates object motion.

---
 rtl/game_judge.sv | 121 ++++++++++++
 1 files changed

// File: rtl/game_judge.sv
// Game judge: collision check of dino vs active obstacles, IDLE/RUN/OVER state machine,
// tick-divided score with saturation, high score, restart pulse and run enable.
module game_judge #(
   parameter int DINO_X          = 50,
   parameter int DINO_W          = 20,
   parameter int DINO_H          = 22,
   parameter int DANGER_W        = 10,
   parameter int DANGER_H        = 20,
   parameter int GROUND          = 200,
   parameter int TICKS_PER_POINT = 4,
   parameter int SCORE_MAX       = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        game_tick,
   input  logic        start_key,
   input  logic [8:0]  dino_pos,
   input  logic [8:0]  danger_pos1,
   input  logic [8:0]  danger_pos2,
   input  logic [8:0]  danger_pos3,
   input  logic [1:0]  danger_num,
   output logic [1:0]  game_state,
   output logic        run_en,
   output logic        obj_rst,
   output logic        hit,
   output logic [13:0] score,
   output logic [13:0] high_score
);

   localparam int CW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2,
      S_BAD  = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   tick_cnt;
   logic            start_go, tick_go, die;
   logic            y_hit, ov1, ov2, ov3, any_hit;

   // 10-bit arithmetic so pos+width cannot wrap at 9 bits
   function automatic logic x_overlap(input logic [8:0] pos);
      logic [9:0] p;
      p = {1'b0, pos};
      return (p < 10'(DINO_X + DINO_W)) && ((p + 10'(DANGER_W)) > 10'(DINO_X));
   endfunction

   always_comb begin
      y_hit   = ({1'b0, dino_pos} + 10'(DINO_H)) > 10'(GROUND - DANGER_H);
      ov1     = x_overlap(danger_pos1);
      ov2     = x_overlap(danger_pos2);
      ov3     = x_overlap(danger_pos3);
      any_hit = y_hit && (((danger_num >= 2'd1) && ov1) ||
                          ((danger_num >= 2'd2) && ov2) ||
                          ((danger_num == 2'd3) && ov3));
   end

   always_comb begin
      state_nxt  = state;
      start_go   = 1'b0;
      tick_go    = 1'b0;
      die        = 1'b0;
      game_state = state;
      run_en     = (state == S_RUN);
      case (state)
         S_IDLE, S_OVER: begin
            if (start_key) begin
               state_nxt = S_RUN;
               start_go  = 1'b1;
            end
         end
         S_RUN: begin
            if (game_tick) begin
               if (any_hit) begin
                  state_nxt = S_OVER;
                  die       = 1'b1;
               end else begin
                  tick_go = 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         obj_rst    <= 1'b0;
         hit        <= 1'b0;
         score      <= '0;
         high_score <= '0;
         tick_cnt   <= '0;
      end else begin
         state   <= state_nxt;
         obj_rst <= start_go;
         if (start_go) begin
            score    <= '0;
            tick_cnt <= '0;
            hit      <= 1'b0;
         end else if (die) begin
            hit <= 1'b1;
         end else if (tick_go) begin
            if (tick_cnt == CW'(TICKS_PER_POINT - 1)) begin
               tick_cnt <= '0;
               if (score < 14'(SCORE_MAX))
                  score <= score + 14'd1;
            end else begin
               tick_cnt <= tick_cnt + CW'(1);
            end
         end
         // score is frozen in OVER, so comparing here lands one clk after entry
         if (state == S_OVER && score > high_score)
            high_score <= score;
      end
   end

endmodule
